// File: rtl/mem_stage_wb.sv
// Memory-access stage and MEM/WB pipeline register: req/ack data-memory handshake with upstream stall.
// Optional abort of long accesses when MEM_TIMEOUT_EN is defined.
module mem_stage_wb #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [63:0]       ALUresult,
    input  logic [63:0]       WriteData,
    input  logic [4:0]        Rd,
    input  logic              WB,
    input  logic [1:0]        M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    input  logic [63:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_rd,
    output logic [63:0]       wb_result,
    output logic              mem_fault
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    logic   mem_op;
    logic   misaligned;
    logic   issue;
    logic   abort;
    logic   done;
    logic   is_load;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        mem_op     = in_valid & (M[1] | M[0]);
        misaligned = mem_op & (ALUresult[2:0] != 3'b000);
        issue      = mem_op & ~misaligned & ~rst;
        abort      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        abort      = issue & (state == WAIT) & ~dmem_ack
                     & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
        // Inputs are frozen by the stall, so WAIT re-derives the request from them.
        dmem_req   = issue & ~abort;
        dmem_we    = M[1];
        dmem_addr  = ALUresult[ADDR_W-1:0];
        dmem_wdata = WriteData;
        done       = dmem_req & dmem_ack;
        stall      = dmem_req & ~dmem_ack;
        is_load    = ~M[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_result   <= '0;
            mem_fault   <= 1'b0;
        end else begin
            state <= stall ? WAIT : IDLE;
            if (stall) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
                mem_fault   <= 1'b0;
            end else if (misaligned || abort) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= 1'b0;
                wb_rd       <= Rd;
                wb_result   <= ALUresult;
                mem_fault   <= 1'b1;
            end else if (done) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= WB & is_load;
                wb_rd       <= Rd;
                wb_result   <= is_load ? dmem_rdata : ALUresult;
                mem_fault   <= M[1] & M[0];
            end else begin
                wb_valid    <= in_valid;
                wb_regwrite <= WB & in_valid;
                wb_rd       <= Rd;
                wb_result   <= ALUresult;
                mem_fault   <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Counts cycles since the request was issued; the IDLE issue cycle is the first.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            wait_cnt <= CNT_W'(1);
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: expected MEM/WB contents queued at drive time, popped after each edge.
module tb_mem_stage_wb;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        f;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] ALUresult;
    logic [63:0] WriteData;
    logic [4:0]  Rd;
    logic        WB;
    logic [1:0]  M;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_result;
    logic        mem_fault;

    wb_t obs;
    wb_t exp_e;
    wb_t last_exp;
    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    assign obs = {wb_valid, wb_regwrite, wb_rd, wb_result, mem_fault};

    always #5 clk = ~clk;

    mem_stage_wb #(.ADDR_W(64), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ALUresult(ALUresult),
        .WriteData(WriteData), .Rd(Rd), .WB(WB), .M(M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_result(wb_result), .mem_fault(mem_fault)
    );

    task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] wd,
                         input logic [4:0] rd, input logic wb, input logic [1:0] m);
        in_valid = v; ALUresult = alu; WriteData = wd; Rd = rd; WB = wb; M = m;
    endtask

    task automatic idle_in();
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 2'b00);
        dmem_ack = 1'b0;
    endtask

    task automatic push(input wb_t e);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    function automatic wb_t bubble();
        return {1'b0, 1'b0, last_exp.rd, last_exp.res, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 64'h100, 64'h0, 5'd4, 1'b1, 2'b01);
        dmem_ack = 1'b1; dmem_rdata = 64'h1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall} !== 2'b00) begin
            n_err++; $display("FAIL reset_comb: req/stall=%b expected 00", {dmem_req, stall});
        end
        tick();
        n_cmp++;
        if (obs !== wb_t'(0)) begin
            n_err++; $display("FAIL reset_regs: got %h expected 0", obs);
        end
        rst = 1'b0;
        last_exp = '0;
        idle_in();
    endtask

    task automatic test_alu_op();
        drive(1'b1, 64'h1234, 64'h0, 5'd5, 1'b1, 2'b00);
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall} !== 2'b00) begin
            n_err++; $display("FAIL alu_comb: req/stall=%b expected 00", {dmem_req, stall});
        end
        push({1'b1, 1'b1, 5'd5, 64'h1234, 1'b0});
        tick();
        exp_e = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_e) begin
            n_err++; $display("FAIL alu_wb: got %h expected %h", obs, exp_e);
        end
        idle_in();
    endtask

    task automatic test_zero_wait_load();
        drive(1'b1, 64'h100, 64'h0, 5'd7, 1'b1, 2'b01);
        dmem_ack = 1'b1; dmem_rdata = 64'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, dmem_we, stall, dmem_addr} !== {3'b100, 64'h100}) begin
            n_err++; $display("FAIL zw_load_comb: req/we/stall/addr=%b/%h expected 100/100",
                              {dmem_req, dmem_we, stall}, dmem_addr);
        end
        push({1'b1, 1'b1, 5'd7, 64'hDEADBEEF, 1'b0});
        tick();
        exp_e = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_e) begin
            n_err++; $display("FAIL zw_load_wb: got %h expected %h", obs, exp_e);
        end
        idle_in();
    endtask

    task automatic test_wait_store();
        drive(1'b1, 64'h208, 64'h55, 5'd3, 1'b1, 2'b10);
        dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {(i != 3), 2'b11, 64'h208, 64'h55}) begin
                n_err++; $display("FAIL store_comb[%0d]: stall/req/we=%b addr=%h wdata=%h expected %b/208/55",
                                  i, {stall, dmem_req, dmem_we}, dmem_addr, dmem_wdata, {(i != 3), 2'b11});
            end
            push(i == 3 ? wb_t'({1'b1, 1'b0, 5'd3, 64'h208, 1'b0}) : bubble());
            tick();
            exp_e = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_e) begin
                n_err++; $display("FAIL store_wb[%0d]: got %h expected %h", i, obs, exp_e);
            end
        end
        idle_in();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 64'h103, 64'h0, 5'd9, 1'b1, 2'b01);
        dmem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, stall} !== 2'b00) begin
                n_err++; $display("FAIL misalign_comb[%0d]: req/stall=%b expected 00", i, {dmem_req, stall});
            end
            push(i == 0 ? wb_t'({1'b1, 1'b0, 5'd9, 64'h103, 1'b1}) : wb_t'(0));
            tick();
            exp_e = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_e) begin
                n_err++; $display("FAIL misalign_wb[%0d]: got %h expected %h", i, obs, exp_e);
            end
            idle_in();
        end
    endtask

    task automatic test_illegal_m();
        drive(1'b1, 64'h40, 64'h77, 5'd12, 1'b1, 2'b11);
        dmem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, dmem_we, stall} !== (i == 0 ? 3'b110 : 3'b000)) begin
                n_err++; $display("FAIL illegal_comb[%0d]: req/we/stall=%b", i, {dmem_req, dmem_we, stall});
            end
            push(i == 0 ? wb_t'({1'b1, 1'b0, 5'd12, 64'h40, 1'b1}) : wb_t'(0));
            tick();
            exp_e = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_e) begin
                n_err++; $display("FAIL illegal_wb[%0d]: got %h expected %h", i, obs, exp_e);
            end
            idle_in();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addr [3] = '{64'h10, 64'h18, 64'h20};
        logic [1:0]  m    [3] = '{2'b01, 2'b10, 2'b01};
        int          waits[3] = '{0, 0, 2};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, addr[k], 64'hA0 + 64'(k), 5'(20 + k), 1'b1, m[k]);
            dmem_rdata = 64'hC0DE_0000 + 64'(k);
            dmem_ack = 1'b0;
            for (int w = 0; w <= waits[k]; w++) begin
                if (w == waits[k]) dmem_ack = 1'b1;
                @(negedge clk);
                n_cmp++;
                if ({dmem_req, stall} !== {1'b1, (w != waits[k])}) begin
                    n_err++; $display("FAIL b2b_comb[%0d.%0d]: req/stall=%b expected %b",
                                      k, w, {dmem_req, stall}, {1'b1, (w != waits[k])});
                end
                if (w != waits[k]) push(bubble());
                else if (m[k] == 2'b01) push({1'b1, 1'b1, 5'(20 + k), 64'hC0DE_0000 + 64'(k), 1'b0});
                else push({1'b1, 1'b0, 5'(20 + k), addr[k], 1'b0});
                tick();
                exp_e = exp_q.pop_front(); n_cmp++;
                if (obs !== exp_e) begin
                    n_err++; $display("FAIL b2b_wb[%0d.%0d]: got %h expected %h", k, w, obs, exp_e);
                end
            end
        end
        idle_in();
    endtask

    task automatic test_ack_ignored();
        drive(1'b0, 64'h80, 64'h0, 5'd6, 1'b1, 2'b01);
        dmem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall} !== 2'b00) begin
            n_err++; $display("FAIL ack_ign_comb: req/stall=%b expected 00", {dmem_req, stall});
        end
        push({1'b0, 1'b0, 5'd6, 64'h80, 1'b0});
        tick();
        exp_e = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_e) begin
            n_err++; $display("FAIL ack_ign_wb: got %h expected %h", obs, exp_e);
        end
        idle_in();
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b1, 64'h300, 64'h0, 5'd15, 1'b1, 2'b01);
        dmem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall} !== 2'b11) begin
            n_err++; $display("FAIL rstwait_issue: req/stall=%b expected 11", {dmem_req, stall});
        end
        push(bubble());
        tick();
        exp_e = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_e) begin
            n_err++; $display("FAIL rstwait_bubble: got %h expected %h", obs, exp_e);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall} !== 2'b00) begin
            n_err++; $display("FAIL rstwait_comb: req/stall=%b expected 00", {dmem_req, stall});
        end
        tick();
        n_cmp++;
        if (obs !== wb_t'(0)) begin
            n_err++; $display("FAIL rstwait_regs: got %h expected 0", obs);
        end
        rst = 1'b0;
        last_exp = '0;
        idle_in();
        dmem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0) begin
            n_err++; $display("FAIL late_ack_req: req=%b expected 0", dmem_req);
        end
        push('0);
        tick();
        exp_e = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_e) begin
            n_err++; $display("FAIL late_ack_wb: got %h expected %h", obs, exp_e);
        end
        idle_in();
    endtask

    task automatic test_long_wait();
`ifdef MEM_TIMEOUT_EN
        // With TIMEOUT_CYCLES=4 an unacked load stalls 3 cycles, then aborts as a fault.
        drive(1'b1, 64'h400, 64'h0, 5'd17, 1'b1, 2'b01);
        dmem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, stall} !== (i < 3 ? 2'b11 : 2'b00)) begin
                n_err++; $display("FAIL timeout_comb[%0d]: req/stall=%b", i, {dmem_req, stall});
            end
            if (i < 3) push(bubble());
            else if (i == 3) push({1'b1, 1'b0, 5'd17, 64'h400, 1'b1});
            else push('0);
            tick();
            exp_e = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_e) begin
                n_err++; $display("FAIL timeout_wb[%0d]: got %h expected %h", i, obs, exp_e);
            end
            if (i == 3) idle_in();
        end
`else
        // Without the timeout a load simply waits until acked, however long.
        drive(1'b1, 64'h400, 64'h0, 5'd17, 1'b1, 2'b01);
        dmem_ack = 1'b0; dmem_rdata = 64'h0BAD_F00D;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) dmem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({dmem_req, stall} !== {1'b1, (i != 7)}) begin
                n_err++; $display("FAIL longwait_comb[%0d]: req/stall=%b", i, {dmem_req, stall});
            end
            push(i == 7 ? wb_t'({1'b1, 1'b1, 5'd17, 64'h0BAD_F00D, 1'b0}) : bubble());
            tick();
            exp_e = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_e) begin
                n_err++; $display("FAIL longwait_wb[%0d]: got %h expected %h", i, obs, exp_e);
            end
        end
        idle_in();
`endif
    endtask

    initial begin
        dmem_rdata = '0;
        dmem_ack   = 1'b0;
        last_exp   = '0;
        test_reset();
        test_alu_op();
        test_zero_wait_load();
        test_wait_store();
        test_misaligned();
        test_illegal_m();
        test_back_to_back();
        test_ack_ignored();
        test_reset_mid_wait();
        test_long_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
